// File: rtl/brick_field.sv
// One row of breakable bricks: each sweep checks the ball against every brick and
// redraws the row pixel by pixel for the VGA adapter.
module brick_field #(
  parameter int          NUM_BRICKS   = 10,
  parameter int          BRICK_W      = 8,
  parameter int          BRICK_H      = 2,
  parameter int          X_OFFSET     = 5,
  parameter int          X_PITCH      = 15,
  parameter int          ROW_Y        = 30,
  parameter logic [2:0]  BRICK_COLOUR = 3'b010
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       restore,
  input  logic [7:0] ball_x,
  input  logic [7:0] ball_y,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       bounce,
  output logic [4:0] remaining,
  output logic       cleared
);

  if (NUM_BRICKS < 1 || NUM_BRICKS > 16 || BRICK_W < 1 || BRICK_W > 16 ||
      BRICK_H < 1 || BRICK_H > 8 || X_PITCH < BRICK_W ||
      X_OFFSET + (NUM_BRICKS - 1) * X_PITCH + BRICK_W > 160 ||
      ROW_Y + BRICK_H > 120) begin : g_param_check
    $error("brick_field: brick geometry does not fit the 160x120 screen");
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAW, S_FINISH} state_t;

  localparam logic [15:0] ALL_ALIVE  = 16'((33'd1 << NUM_BRICKS) - 33'd1);
  localparam logic [3:0]  COL_LAST   = 4'(BRICK_W - 1);
  localparam logic [2:0]  ROW_LAST   = 3'(BRICK_H - 1);
  localparam logic [3:0]  LAST_BRICK = 4'(NUM_BRICKS - 1);
  localparam logic [7:0]  TOP_Y      = 8'(ROW_Y);
  localparam logic [7:0]  BOT_Y      = 8'(ROW_Y + BRICK_H - 1);

  state_t      state;
  logic [3:0]  i;
  logic [3:0]  col;
  logic [2:0]  row;
  logic [15:0] alive;
  logic        hit_seen;

  logic [4:0]  chk_idx;
  logic [15:0] alive_eff;
  logic [7:0]  chk_bx;
  logic        chk_hit;

  function automatic logic [7:0] brick_x(input logic [4:0] idx);
    return 8'(X_OFFSET) + 8'(idx) * 8'(X_PITCH);
  endfunction

  // Hit test for the brick about to enter CHECK, so bounce can be registered on entry.
  // A restore issued together with start is already visible here.
  always_comb begin
    chk_idx   = (state == S_IDLE) ? 5'd0 : {1'b0, i} + 5'd1;
    alive_eff = (state == S_IDLE && restore) ? ALL_ALIVE : alive;
    chk_bx    = brick_x(chk_idx);
    chk_hit   = 1'b0;
    if (chk_idx < 5'(NUM_BRICKS) && alive_eff[chk_idx[3:0]] &&
        !(state != S_IDLE && hit_seen) &&
        ball_x >= chk_bx && ball_x <= chk_bx + 8'(BRICK_W - 1) &&
        ball_y >= TOP_Y && ball_y <= BOT_Y)
      chk_hit = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      i         <= '0;
      col       <= '0;
      row       <= '0;
      alive     <= ALL_ALIVE;
      hit_seen  <= 1'b0;
      remaining <= 5'(NUM_BRICKS);
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bounce    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (restore) begin
            alive     <= ALL_ALIVE;
            remaining <= 5'(NUM_BRICKS);
          end
          if (start) begin
            state    <= S_CHECK;
            i        <= '0;
            busy     <= 1'b1;
            hit_seen <= 1'b0;
            bounce   <= chk_hit;
          end
        end
        S_CHECK: begin
          bounce <= 1'b0;
          if (bounce) begin
            alive[i]  <= 1'b0;
            remaining <= remaining - 5'd1;
            hit_seen  <= 1'b1;
          end
          state  <= S_DRAW;
          col    <= '0;
          row    <= '0;
          plot   <= 1'b1;
          x      <= brick_x({1'b0, i});
          y      <= TOP_Y;
          colour <= (alive[i] && !bounce) ? BRICK_COLOUR : 3'b000;
        end
        S_DRAW: begin
          if (col == COL_LAST && row == ROW_LAST) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            if (i == LAST_BRICK) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state  <= S_CHECK;
              i      <= i + 4'd1;
              bounce <= chk_hit;
            end
          end else if (col == COL_LAST) begin
            col <= '0;
            row <= row + 3'd1;
            x   <= brick_x({1'b0, i});
            y   <= TOP_Y + 8'(row) + 8'd1;
          end else begin
            col <= col + 4'd1;
            x   <= x + 8'd1;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cleared = (remaining == 5'd0);

endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 Parameter NUM_BRICKS, default 10: bricks in the row, 1..16.
REQ-002 Parameter BRICK_W, default 8: brick width in pixels, 1..16.
REQ-003 Parameter BRICK_H, default 2: brick height in pixels, 1..8.
REQ-004 Parameter X_OFFSET, default 5: x of brick 0.
REQ-005 Parameter X_PITCH, default 15: x spacing between brick origins, at least BRICK_W.
REQ-006 Parameter ROW_Y, default 30: y of every brick origin.
REQ-007 Parameter BRICK_COLOUR, default 3'b010: colour of a live brick.
REQ-008 Elaboration SHALL fail unless X_OFFSET+(NUM_BRICKS-1)*X_PITCH+BRICK_W <= 160 and ROW_Y+BRICK_H <= 120.
REQ-009 Port CLOCK_50, input, 1: the single clock; all state changes on its rising edge.
REQ-010 Port resetn, input, 1: asynchronous, active-low reset.
REQ-011 Port start, input, 1: request one sweep; sampled only in IDLE.
REQ-012 Port restore, input, 1: revive all bricks; sampled only in IDLE.
REQ-013 Port ball_x, input, 8: ball x; stable while busy=1.
REQ-014 Port ball_y, input, 8: ball y; stable while busy=1.
REQ-015 Port x, output, 8: pixel x to the VGA adapter.
REQ-016 Port y, output, 8: pixel y to the VGA adapter.
REQ-017 Port colour, output, 3: pixel colour.
REQ-018 Port plot, output, 1: pixel valid this cycle.
REQ-019 Port busy, output, 1: high from the cycle after start is accepted until done.
REQ-020 Port done, output, 1: one-cycle pulse ending a sweep.
REQ-021 Port bounce, output, 1: one-cycle pulse when a brick is hit; caller inverts ball y direction.
REQ-022 Port remaining, output, 5: count of live bricks.
REQ-023 Port cleared, output, 1: high when remaining = 0.

Function
REQ-024 State SHALL be one of IDLE, CHECK, DRAW, FINISH, with a brick index i, a column counter and a row counter.
REQ-025 Brick i origin: bx = X_OFFSET + i*X_PITCH, by = ROW_Y; all coordinate arithmetic is 8-bit unsigned, with no wrap guaranteed by REQ-008.
REQ-026 In IDLE with restore=1, all alive bits are set and remaining becomes NUM_BRICKS on the next edge.
REQ-027 IDLE with start=1: i=0 and go to CHECK next cycle; restore and start together means restore applies first, then the sweep sees all bricks alive.
REQ-028 start while not in IDLE is ignored; no queuing.
REQ-029 A hit requires all of: brick alive, ball_x in [bx, bx+BRICK_W-1], ball_y in [by, by+BRICK_H-1], and no hit yet in this sweep.
REQ-030 CHECK lasts 1 cycle with plot=0; on a hit, bounce=1 that cycle, the alive bit clears and remaining decrements by 1 at the edge.
REQ-031 At most one bounce per sweep, on the lowest-index hit brick.
REQ-032 DRAW lasts exactly BRICK_W*BRICK_H cycles with plot=1, row-major, emitting x=bx+col and y=by+row.
REQ-033 DRAW colour = BRICK_COLOUR if the brick is alive after CHECK, else 3'b000.
REQ-034 After the last DRAW pixel: if i<NUM_BRICKS-1, increment i and go to CHECK; otherwise go to FINISH.
REQ-035 FINISH lasts 1 cycle with done=1, busy=1 and plot=0, then returns to IDLE.
REQ-036 Sweep latency: done is high exactly NUM_BRICKS*(1+BRICK_W*BRICK_H)+1 cycles after the start cycle; 171 cycles at defaults.
REQ-037 Whenever plot=0, x=0, y=0 and colour=0.

Reset
REQ-038 resetn=0 SHALL immediately force: state IDLE, i and counters 0, all bricks alive, remaining=NUM_BRICKS, and x, y, colour, plot, busy, done, bounce all 0.
REQ-039 Reset mid-sweep abandons the sweep with no done pulse; the first edge after release begins in IDLE.

Verification
REQ-040 Reset; ball (0,100); start -> 160 plots of colour 010, first (5,30), last (147,31), done at cycle 171, no bounce, remaining=10.
REQ-041 Ball (22,31); start -> bounce at cycle 18 (brick 1 CHECK), brick 1 drawn in 000, remaining=9; a second sweep with the same ball gives no bounce.
REQ-042 Edge cases: ball (27,30) hits brick 1; ball (28,30) in the gap gives no hit; ball (20,32) below the row gives no hit.
REQ-043 Assert resetn=0 at cycle 50 of a sweep -> plot and busy 0 at once, remaining=10, no done pulse; a new start then completes normally.
REQ-044 Clear all 10 bricks over successive sweeps -> cleared=1, remaining=0; restore and start in the same cycle -> all 10 drawn in 010, remaining=10.
